// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 hex keypad scanner.
// Holds the debounce FSM state codes, the per-frame scan result encoding
// and the row/column to hex-digit key map (Digilent PmodKYPD layout).
package keypad_pkg;

  typedef enum logic [1:0] {
    KP_IDLE     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_PRESSED  = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_res_e;

  // Row r (top to bottom), column c (left to right) to hex digit.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Number of asserted (low) bits in an active-low row sample.
  function automatic logic [2:0] count_low(input logic [3:0] row_n);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, ~row_n[i]};
    end
    return cnt;
  endfunction

  // Index of the lowest asserted (low) row bit; only meaningful when one is low.
  function automatic logic [1:0] low_index(input logic [3:0] row_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_n[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: CPU-side IO bus of the keypad scanner.
// master = CPU (drives ACK/CLR pulses), slave = scanner (drives status/data).
interface keypad_scanner_if;
  logic        ACK;
  logic        CLR;
  logic [31:0] DATA;
  logic [3:0]  KEY_CODE;
  logic        KEY_VALID;
  logic        PENDING;
  logic        OVERRUN;

  modport master (
    output ACK, CLR,
    input  DATA, KEY_CODE, KEY_VALID, PENDING, OVERRUN
  );

  modport slave (
    input  ACK, CLR,
    output DATA, KEY_CODE, KEY_VALID, PENDING, OVERRUN
  );
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level press/release debouncer.
// Evaluated once per frame strobe; emits a combinational accept pulse and code
// so the scanner can register its outputs on the frame-ending edge.
// Optional autorepeat is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_end_i,
  input  frame_res_e frame_res_i,
  input  logic [3:0] frame_code_i,
  output logic       accept_o,
  output logic [3:0] accept_code_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  localparam logic [1:0] S_IDLE     = KP_IDLE;
  localparam logic [1:0] S_DEBOUNCE = KP_DEBOUNCE;
  localparam logic [1:0] S_PRESSED  = KP_PRESSED;
  localparam logic [1:0] S_RELEASE  = KP_RELEASE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [3:0]       cand_q, cand_d;
  logic             is_key_s;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES);
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc_s;
`else
  logic unused_repeat_cfg_s;
  assign unused_repeat_cfg_s = (REPEAT_FRAMES > 0);
`endif

  assign accept_code_o = frame_code_i;

  // Next-state, counter and accept logic, advanced only on a frame strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    accept_o  = 1'b0;
    cnt_inc_s = cnt_q + CNT_ONE;
    is_key_s  = (frame_res_i == FR_KEY);
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d     = rpt_q;
    rpt_inc_s = rpt_q + RPT_W'(1);
`endif
    if (frame_end_i) begin
      case (state_q)
        S_IDLE: begin
          if (is_key_s) begin
            cand_d = frame_code_i;
            cnt_d  = CNT_ONE;
            if (CNT_ONE == CNT_LAST) begin
              accept_o = 1'b1;
              state_d  = S_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_d    = '0;
`endif
            end else begin
              state_d = S_DEBOUNCE;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_DEBOUNCE: begin
          if (is_key_s && (frame_code_i == cand_q)) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == CNT_LAST) begin
              accept_o = 1'b1;
              state_d  = S_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_d    = '0;
`endif
            end else begin
              state_d = S_DEBOUNCE;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (!is_key_s) begin
            if (CNT_ONE == CNT_LAST) begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (frame_code_i == cand_q) begin
              if (rpt_inc_s == RPT_LAST) begin
                accept_o = 1'b1;
                rpt_d    = '0;
              end else begin
                rpt_d = rpt_inc_s;
              end
            end else begin
              rpt_d = '0;
            end
`endif
          end
        end
        S_RELEASE: begin
          if (!is_key_s) begin
            if (cnt_inc_s == CNT_LAST) begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d   = cnt_inc_s;
              state_d = S_RELEASE;
            end
          end else begin
            // A bounce during release: back to held, no new accept.
            cnt_d   = '0;
            state_d = S_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_d   = '0;
`endif
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM state, debounce count and candidate code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad controller on the CPU IO bus.
// Drives one column low at a time, samples the synchronized active-low rows at
// the end of each column dwell, assembles a 4-column frame, debounces it and
// shifts accepted digits into a 32-bit entry register.
// Optional autorepeat: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_BITS      = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 64
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [3:0]       ROW,
  output logic [3:0]       COL,
  keypad_scanner_if.slave  bus
);

  logic [3:0]           row_meta_q, row_sync_q;
  logic [SCAN_BITS-1:0] presc_q, presc_d;
  logic [1:0]           col_q, col_d;
  logic [3:0]           col_drv_q, col_drv_d;
  logic [1:0]           low_acc_q, low_acc_d;
  logic [3:0]           code_acc_q, code_acc_d;

  logic                 sample_s, frame_end_s;
  logic [2:0]           sample_low_s, low_sum_s;
  logic [1:0]           base_low_s;
  logic [3:0]           base_code_s;
  frame_res_e           frame_res_s;
  logic                 accept_s;
  logic [3:0]           accept_code_s;

  logic [31:0]          data_q, data_d;
  logic [3:0]           key_code_q, key_code_d;
  logic                 key_valid_q, key_valid_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;

  // Prescaler, column index and registered column drive.
  always_comb begin
    presc_d   = presc_q + SCAN_BITS'(1);
    sample_s  = &presc_q;
    col_d     = sample_s ? (col_q + 2'd1) : col_q;
    col_drv_d = ~(4'b0001 << col_d);
  end

  // Frame assembly: accumulate low-bit count (saturating at 2) and the code.
  always_comb begin
    sample_low_s = count_low(row_sync_q);
    base_low_s   = (col_q == 2'd0) ? 2'd0 : low_acc_q;
    base_code_s  = (col_q == 2'd0) ? 4'h0 : code_acc_q;
    low_sum_s    = {1'b0, base_low_s} + sample_low_s;
    if (sample_s) begin
      low_acc_d  = (low_sum_s >= 3'd2) ? 2'd2 : low_sum_s[1:0];
      code_acc_d = (sample_low_s == 3'd1) ? key_map(low_index(row_sync_q), col_q) : base_code_s;
    end else begin
      low_acc_d  = low_acc_q;
      code_acc_d = code_acc_q;
    end
    frame_end_s = sample_s && (col_q == 2'd3);
    case (low_acc_d)
      2'd0:    frame_res_s = FR_NONE;
      2'd1:    frame_res_s = FR_KEY;
      default: frame_res_s = FR_MULTI;
    endcase
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_FRAMES  (REPEAT_FRAMES)
  ) u_debounce (
    .clk           (CLK),
    .rst           (RES),
    .frame_end_i   (frame_end_s),
    .frame_res_i   (frame_res_s),
    .frame_code_i  (code_acc_d),
    .accept_o      (accept_s),
    .accept_code_o (accept_code_s)
  );

  // Output register next values, including CLR/ACK coinciding with an accept.
  always_comb begin
    key_valid_d = accept_s;
    if (accept_s) begin
      data_d     = bus.CLR ? {28'h0, accept_code_s} : {data_q[27:0], accept_code_s};
      key_code_d = accept_code_s;
      pending_d  = 1'b1;
      overrun_d  = bus.ACK ? 1'b0 : (overrun_q | pending_q);
    end else begin
      data_d     = bus.CLR ? 32'h0 : data_q;
      key_code_d = key_code_q;
      pending_d  = bus.ACK ? 1'b0 : pending_q;
      overrun_d  = bus.ACK ? 1'b0 : overrun_q;
    end
  end

  // Row synchronizer, scan state and output registers.
  always_ff @(posedge CLK) begin
    if (RES) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      presc_q     <= '0;
      col_q       <= 2'd0;
      col_drv_q   <= 4'b1110;
      low_acc_q   <= 2'd0;
      code_acc_q  <= 4'h0;
      data_q      <= 32'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      row_meta_q  <= ROW;
      row_sync_q  <= row_meta_q;
      presc_q     <= presc_d;
      col_q       <= col_d;
      col_drv_q   <= col_drv_d;
      low_acc_q   <= low_acc_d;
      code_acc_q  <= code_acc_d;
      data_q      <= data_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  assign COL           = col_drv_q;
  assign bus.DATA      = data_q;
  assign bus.KEY_CODE  = key_code_q;
  assign bus.KEY_VALID = key_valid_q;
  assign bus.PENDING   = pending_q;
  assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_BITS=3
// (8-clock dwell, 32-clock frame) and DEBOUNCE_SCANS=2. A keypad model pulls
// a row low whenever a pressed key's column is driven low.
module tb_keypad_scanner;

  localparam int FRAME = 32;

  logic        clk = 1'b0;
  logic        res;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys;   // bit r*4+c = key at row r, column c held down

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0;

  logic [3:0] col_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          rel;
    logic        ack;
    int          kv;
    logic [31:0] data;
    logic [3:0]  code;
    logic        pend;
    logic        ovr;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  keypad_scanner_if bus();

  keypad_scanner #(
    .SCAN_BITS      (3),
    .DEBOUNCE_SCANS (2),
    .REPEAT_FRAMES  (4)
  ) dut (
    .CLK (clk),
    .RES (res),
    .ROW (row),
    .COL (col),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Keypad model: row r low when any held key in that row sits on a low column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.KEY_VALID === 1'b1) kv_cnt++;
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  // Hold reset for three edges, check reset values, release aligned to a frame start.
  task automatic do_reset(input string tag);
    res = 1'b1;
    repeat (3) tick();
    check({tag, " COL"},       {28'h0, col},           32'hE);
    check({tag, " DATA"},      bus.DATA,               32'h0);
    check({tag, " KEY_CODE"},  {28'h0, bus.KEY_CODE},  32'h0);
    check({tag, " KEY_VALID"}, {31'h0, bus.KEY_VALID}, 32'h0);
    check({tag, " PENDING"},   {31'h0, bus.PENDING},   32'h0);
    check({tag, " OVERRUN"},   {31'h0, bus.OVERRUN},   32'h0);
    res = 1'b0;
  endtask

  // Hold k so it is accepted at the end of frame 2, pulsing clr/ack in that exact cycle.
  task automatic accept_with(input logic [15:0] k, input logic clr, input logic ack,
                             output logic kv, output logic [31:0] data);
    keys = k;
    frames(1);
    repeat (FRAME - 1) tick();
    bus.CLR = clr;
    bus.ACK = ack;
    tick();
    bus.CLR = 1'b0;
    bus.ACK = 1'b0;
    kv   = bus.KEY_VALID;
    data = bus.DATA;
    keys = 16'h0;
    frames(2);
  endtask

  initial begin
    logic        kv;
    logic [31:0] d;

    //        keys      hold rel ack  kv  data          code  pend  ovr
    vecs[0]  = '{16'h0040, 3, 3, 1'b0, 1, 32'h0000_0006, 4'h6, 1'b1, 1'b0};
    vecs[1]  = '{16'h0001, 2, 2, 1'b0, 1, 32'h0000_0061, 4'h1, 1'b1, 1'b1};
    vecs[2]  = '{16'h0002, 2, 2, 1'b0, 1, 32'h0000_0612, 4'h2, 1'b1, 1'b1};
    vecs[3]  = '{16'h0004, 2, 2, 1'b0, 1, 32'h0000_6123, 4'h3, 1'b1, 1'b1};
    vecs[4]  = '{16'h0008, 2, 2, 1'b0, 1, 32'h0006_123A, 4'hA, 1'b1, 1'b1};
    vecs[5]  = '{16'h0010, 2, 2, 1'b0, 1, 32'h0061_23A4, 4'h4, 1'b1, 1'b1};
    vecs[6]  = '{16'h0020, 2, 2, 1'b0, 1, 32'h0612_3A45, 4'h5, 1'b1, 1'b1};
    vecs[7]  = '{16'h0040, 2, 2, 1'b0, 1, 32'h6123_A456, 4'h6, 1'b1, 1'b1};
    vecs[8]  = '{16'h0080, 2, 2, 1'b0, 1, 32'h123A_456B, 4'hB, 1'b1, 1'b1};
    vecs[9]  = '{16'h0100, 2, 2, 1'b0, 1, 32'h23A4_56B7, 4'h7, 1'b1, 1'b1};
    vecs[10] = '{16'h0200, 1, 2, 1'b1, 0, 32'h23A4_56B7, 4'h7, 1'b0, 1'b0};
    vecs[11] = '{16'h8001, 3, 2, 1'b0, 0, 32'h23A4_56B7, 4'h7, 1'b0, 1'b0};

    res     = 1'b1;
    keys    = 16'h0;
    bus.ACK = 1'b0;
    bus.CLR = 1'b0;
    do_reset("reset");

    // Idle for 10 frames: column walk every 8 clocks, nothing accepted.
    kv_cnt = 0;
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("idle COL f%0d c%0d", f, c), {28'h0, col}, {28'h0, col_exp[c]});
        repeat (8) tick();
      end
    end
    check("idle KEY_VALID count", kv_cnt, 0);
    check("idle DATA", bus.DATA, 32'h0);

    // Table: single presses, wrap of the entry register, ACK, short press, two keys.
    for (int i = 0; i < NV; i++) begin
      kv_cnt  = 0;
      keys    = vecs[i].keys;
      bus.ACK = vecs[i].ack;
      tick();
      bus.ACK = 1'b0;
      if (vecs[i].ack) begin
        check($sformatf("v%0d ack PENDING", i), {31'h0, bus.PENDING}, 32'h0);
        check($sformatf("v%0d ack OVERRUN", i), {31'h0, bus.OVERRUN}, 32'h0);
      end
      repeat (vecs[i].hold * FRAME - 1) tick();
      keys = 16'h0;
      frames(vecs[i].rel);
      check($sformatf("v%0d KEY_VALID count", i), kv_cnt, vecs[i].kv);
      check($sformatf("v%0d DATA", i), bus.DATA, vecs[i].data);
      check($sformatf("v%0d KEY_CODE", i), {28'h0, bus.KEY_CODE}, {28'h0, vecs[i].code});
      check($sformatf("v%0d PENDING", i), {31'h0, bus.PENDING}, {31'h0, vecs[i].pend});
      check($sformatf("v%0d OVERRUN", i), {31'h0, bus.OVERRUN}, {31'h0, vecs[i].ovr});
    end

    // Accept with PENDING clear: no overrun.
    kv_cnt = 0;
    keys = 16'h0400;
    frames(2);
    keys = 16'h0;
    frames(2);
    check("nine KEY_VALID count", kv_cnt, 1);
    check("nine DATA", bus.DATA, 32'h3A45_6B79);
    check("nine OVERRUN", {31'h0, bus.OVERRUN}, 32'h0);

    // One-frame release bounce must not produce a second accept.
    kv_cnt = 0;
    keys = 16'h0080;
    frames(2);
    keys = 16'h0;
    frames(1);
    keys = 16'h0080;
    frames(2);
    keys = 16'h0;
    frames(2);
    check("bounce KEY_VALID count", kv_cnt, 1);
    check("bounce DATA", bus.DATA, 32'hA456_B79B);
    check("bounce OVERRUN", {31'h0, bus.OVERRUN}, 32'h1);

    // CLR in the accepting cycle of F.
    accept_with(16'h2000, 1'b1, 1'b0, kv, d);
    check("clr+accept KEY_VALID", {31'h0, kv}, 32'h1);
    check("clr+accept DATA", d, 32'h0000_000F);
    check("clr+accept KEY_CODE", {28'h0, bus.KEY_CODE}, 32'hF);
    check("clr+accept OVERRUN", {31'h0, bus.OVERRUN}, 32'h1);

    // ACK in the accepting cycle of E.
    accept_with(16'h4000, 1'b0, 1'b1, kv, d);
    check("ack+accept KEY_VALID", {31'h0, kv}, 32'h1);
    check("ack+accept DATA", d, 32'h0000_00FE);
    check("ack+accept PENDING", {31'h0, bus.PENDING}, 32'h1);
    check("ack+accept OVERRUN", {31'h0, bus.OVERRUN}, 32'h0);

    // CLR alone clears DATA only.
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    check("clr DATA", bus.DATA, 32'h0);
    check("clr PENDING", {31'h0, bus.PENDING}, 32'h1);
    check("clr KEY_CODE", {28'h0, bus.KEY_CODE}, 32'hE);
    repeat (FRAME - 1) tick();

    // Reset in the middle of debounce, key held through it.
    keys = 16'h0001;
    frames(1);
    repeat (10) tick();
    do_reset("mid-debounce reset");
    kv_cnt = 0;
    frames(1);
    check("post-reset 1 frame KEY_VALID count", kv_cnt, 0);
    frames(1);
    check("post-reset 2 frames KEY_VALID count", kv_cnt, 1);
    check("post-reset DATA", bus.DATA, 32'h1);
    check("post-reset PENDING", {31'h0, bus.PENDING}, 32'h1);
    check("post-reset OVERRUN", {31'h0, bus.OVERRUN}, 32'h0);
    keys = 16'h0;
    frames(2);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Autorepeat: hold 7 for 12 frames with a 4-frame repeat interval.
    do_reset("autorepeat reset");
    kv_cnt = 0;
    keys = 16'h0100;
    frames(12);
    check("autorepeat KEY_VALID count", kv_cnt, 3);
    check("autorepeat DATA", bus.DATA, 32'h0000_0777);
    keys = 16'h0;
    frames(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Hex keypad input controller: scans a 4x4 matrix keypad (Digilent PmodKYPD layout) by driving columns low one at a time and sampling active-low rows. It debounces, decodes each accepted press to a 4-bit hex code and shifts it into a 32-bit entry register. It sits on the CPU IO bus as the input-side counterpart of the 8-digit hex display: the CPU polls `PENDING`, reads `DATA`/`KEY_CODE`, and pulses `ACK`.

## Interface
- `SCAN_BITS`, default 17: column dwell is 2^SCAN_BITS clocks (~762 Hz column rate at 100 MHz).
- `DEBOUNCE_SCANS`, default 4, min 1: consecutive identical frames required to accept a press or a release.
- `REPEAT_FRAMES`, default 64: autorepeat interval in frames. Used only with `KEYPAD_AUTOREPEAT_EN`.
- `CLK` in 1: system clock.
- `RES` in 1: reset, synchronous, active-high.
- `ROW` in 4: keypad rows, active-low, asynchronous to `CLK`.
- `COL` out 4: keypad columns, active-low, exactly one bit low at any time.
- `ACK` in 1: one-cycle pulse; clears `PENDING` and `OVERRUN`.
- `CLR` in 1: one-cycle pulse; clears `DATA` to 0.
- `DATA` out 32: entry register, newest digit in `[3:0]`.
- `KEY_CODE` out 4: last accepted code.
- `KEY_VALID` out 1: one-cycle pulse per accepted key.
- `PENDING` out 1: an accepted key has not yet been acknowledged.
- `OVERRUN` out 1: a key was accepted while `PENDING` was already 1.

## Operation
- `ROW` passes through a 2-flop synchronizer before any use.
- Free-running prescaler of width `SCAN_BITS`. The column index (0..3) advances when the prescaler wraps. `COL[c]` = 0 for the active column c.
- The synchronized `ROW` is sampled in the last prescaler cycle of each column dwell (prescaler all-ones). Four samples make one frame, columns 0..3.
- Frame result:
  - NONE: no low row bit in any sample.
  - KEY(code): exactly one low bit across the whole frame.
  - MULTI: two or more low bits. MULTI is treated as NONE for acceptance and breaks any debounce count.
- Key map, row r top-to-bottom, column c left-to-right:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM states and transitions, evaluated once per frame end:
  - IDLE: KEY(k) loads candidate k with count 1 and goes to DEBOUNCE. If `DEBOUNCE_SCANS` = 1, it accepts immediately and goes to PRESSED.
  - DEBOUNCE: the same KEY(k) increments count. When count reaches `DEBOUNCE_SCANS`, the key is accepted and the state goes to PRESSED. Any other result returns to IDLE.
  - PRESSED: no further acceptance (autorepeat excepted). NONE or MULTI starts a release count and goes to RELEASE.
  - RELEASE: NONE or MULTI increments the release count; reaching `DEBOUNCE_SCANS` goes to IDLE. KEY of any code returns to PRESSED and the new code is not accepted.
- On accept:
  - `DATA <= {DATA[27:0], k}`, `KEY_CODE <= k`.
  - `KEY_VALID` = 1 for one cycle.
  - `PENDING <= 1`; `OVERRUN <= 1` if `PENDING` was already 1.
- Simultaneous events:
  - `CLR` with accept: `DATA` = {28'h0, k}.
  - `ACK` with accept: `PENDING` = 1, `OVERRUN` = 0.
  - `CLR` does not affect `PENDING` or `KEY_CODE`.
- `DATA` wraps silently: after 8 digits the oldest digit is shifted out.

## Timing
- Reset values:
  - `COL` = 4'b1110.
  - `DATA`, `KEY_CODE` = 0.
  - `KEY_VALID`, `PENDING`, `OVERRUN` = 0.
  - Prescaler = 0, column = 0, FSM = IDLE, all counts = 0.
- Reset mid-operation aborts any debounce. A key held through reset is re-debounced and accepted as a fresh press.
- Frame length is 4·2^SCAN_BITS cycles.
- `KEY_VALID`, `DATA`, `KEY_CODE`, `PENDING` and `OVERRUN` all update on the clock edge immediately after the column-3 sample of the qualifying frame.
- `ROW`-to-sample latency is 2 synchronizer cycles plus up to one column dwell. A column drive has 2^SCAN_BITS−1 cycles to settle before its sample.
- `ACK`/`CLR` take effect on the next edge.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined: in PRESSED, every `REPEAT_FRAMES` consecutive frames of the same KEY(k) re-accept k (full accept behaviour). The repeat counter resets on entry to PRESSED.
- `KEYPAD_AUTOREPEAT_EN` undefined: exactly one accept per press. No repeat counter is synthesized.

## Structure
- `keypad_pkg`: FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE), frame-result encoding, and the row/column-to-hex key-map function.
- Sub-module `keypad_debounce`: frame-level FSM, counters and autorepeat. Takes frame result plus frame strobe; emits accept plus code.
- Top-level `keypad_scanner` keeps the prescaler, column drive, synchronizer, frame assembly and output registers.

## Test plan
Bench uses `SCAN_BITS`=3, `DEBOUNCE_SCANS`=2, keypad model pulling a row low when its column is low.
- Reset then idle 10 frames -> `COL` cycles 1110,1101,1011,0111 every 8 clocks; `DATA`=0; no `KEY_VALID`.
- Hold r1c2 for 3 frames, then release -> one `KEY_VALID`, `KEY_CODE`=6, `DATA`=0x6, `PENDING`=1; no second pulse after release.
- Press 1,2,3,A,4,5,6,B,7 with releases between -> `DATA`=0x23A456B7 (wrap); `OVERRUN`=1; then `ACK` -> `PENDING`=0 and `OVERRUN`=0.
- Key present for 1 frame only, or r0c0+r3c3 held together -> no accept.
- `CLR` in the same cycle as accepting r3c1 (F) -> `DATA`=0x0000000F. `RES` asserted mid-DEBOUNCE -> all outputs at reset values, FSM IDLE.
- With `KEYPAD_AUTOREPEAT_EN`, `REPEAT_FRAMES`=4, hold r2c0 for 12 frames -> `KEY_VALID` count 3, `DATA`=0x777.
